fetch_sequencer: RTL and testbench

Controller that owns the instruction-fetch stage from outside the pipeline. It fills instruction RAM from a byte stream (UART receiver side). It then sequences execution in continuous or single-step mode by gating the PC enable and holding the pipeline reset. It sits between the UART RX / debug path and the fetch stage's write port, pc_enable input and pipeline reset.

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer_word_assembler.sv | 48 ++++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the instruction-fetch sequencer: FSM states,
// command bytes and the default load terminator.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_sequencer_word_assembler.sv
// Packs a byte stream MSB-first into words and emits a one-cycle
// word_valid on the cycle after the last byte of each word.
module fetch_sequencer_word_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    logic [CNT_W-1:0] byte_cnt;
    logic [WIDTH-9:0] shift_q;

    // The counter wraps on the last byte itself, so a byte arriving during
    // the following write cycle already starts the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            shift_q    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
                shift_q  <= '0;
            end else if (byte_valid) begin
                shift_q <= {shift_q[WIDTH-17:0], byte_data};
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt   <= '0;
                    word_valid <= 1'b1;
                    word       <= {shift_q, byte_data};
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Loads instruction RAM from a UART byte stream and sequences execution
// (continuous or single-step) through PC enable and pipeline reset.
//
//   state | meaning
//   IDLE  | pipeline held in reset, waiting for L/C/S
//   LOAD  | assembling bytes into words and writing instruction RAM
//   RUN   | PC enabled until the pipeline reports halt
//   STEP  | one PC-enable pulse per 'N' byte until halt
//   DONE  | halted, pipeline out of reset for inspection; accepts L/C/S
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              len        = 32,
    parameter int              ADDR_WIDTH = 11,
    parameter logic [len-1:0]  HALT_WORD  = len'(DEFAULT_HALT_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_rx_data,
    input  logic                  in_rx_valid,
    input  logic                  in_halt,
    output logic                  out_mem_we,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [len-1:0]        out_mem_wdata,
    output logic                  out_pc_enable,
    output logic                  out_pipe_reset,
    output logic [2:0]            out_state,
    output logic [ADDR_WIDTH:0]   out_word_count,
    output logic                  out_error
);

    localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t state_q, state_d;
    state_t target_q, target_d;
    logic   restart_q, restart_d;
    logic   step_pulse_q, step_pulse_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   word_count_q;
    logic                  error_q;

    logic           asm_valid;
    logic [len-1:0] asm_word;
    logic           cmd_valid;
    logic           load_entry;
    logic           write_strobe;
    logic           is_halt_word;
    logic           ram_full;

    assign cmd_valid    = in_rx_valid && !restart_q && (state_q == ST_IDLE || state_q == ST_DONE);
    assign load_entry   = cmd_valid && (in_rx_data == CMD_LOAD);
    assign write_strobe = asm_valid && (state_q == ST_LOAD);
    assign is_halt_word = (asm_word == HALT_WORD);
    assign ram_full     = (word_count_q == LAST_SLOT);

    fetch_sequencer_word_assembler #(.WIDTH(len)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_entry),
        .byte_valid (in_rx_valid && (state_q == ST_LOAD)),
        .byte_data  (in_rx_data),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    // A restart from DONE spends one cycle in DONE with the pipeline held
    // in reset, so execution begins again from PC 0.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        restart_d    = 1'b0;
        step_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (restart_q) begin
                    state_d = target_q;
                end else if (cmd_valid) begin
                    case (in_rx_data)
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_CONT, CMD_STEP: begin
                            target_d = (in_rx_data == CMD_CONT) ? ST_RUN : ST_STEP;
                            if (state_q == ST_DONE) restart_d = 1'b1;
                            else                    state_d   = target_d;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (write_strobe && (is_halt_word || ram_full)) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (in_halt) state_d = ST_DONE;
            end
            ST_STEP: begin
                if (in_halt)                                         state_d      = ST_DONE;
                else if (in_rx_valid && (in_rx_data == CMD_NEXT))    step_pulse_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            target_q     <= ST_RUN;
            restart_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            addr_q       <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            restart_q    <= restart_d;
            step_pulse_q <= step_pulse_d;
            if (load_entry) begin
                addr_q       <= '0;
                word_count_q <= '0;
                error_q      <= 1'b0;
            end else if (write_strobe) begin
                addr_q       <= addr_q + 1'b1;
                word_count_q <= word_count_q + 1'b1;
                if (!is_halt_word && ram_full) error_q <= 1'b1;
            end
        end
    end

    assign out_mem_we     = write_strobe;
    assign out_mem_addr   = addr_q;
    assign out_mem_wdata  = asm_word;
    assign out_pc_enable  = (state_q == ST_RUN) || step_pulse_q;
    assign out_pipe_reset = (state_q == ST_IDLE) || (state_q == ST_LOAD) || restart_q;
    assign out_state      = state_q;
    assign out_word_count = word_count_q;
    assign out_error      = error_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Drives a full-size and a 4-word sequencer with the same randomized
// byte stream and checks them against a word-level load model.
module tb_fetch_sequencer;

    localparam int AW_B = 11;
    localparam int AW_S = 2;
    localparam logic [7:0]  B_L  = 8'h4C;
    localparam logic [7:0]  B_C  = 8'h43;
    localparam logic [7:0]  B_S  = 8'h53;
    localparam logic [7:0]  B_N  = 8'h4E;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset, rx_valid, halt;
    logic [7:0] rx_data;

    logic we_b, pe_b, pr_b, err_b;
    logic [AW_B-1:0] addr_b;
    logic [31:0] wd_b;
    logic [2:0] st_b;
    logic [AW_B:0] wc_b;
    logic we_s, pe_s, pr_s, err_s;
    logic [AW_S-1:0] addr_s;
    logic [31:0] wd_s;
    logic [2:0] st_s;
    logic [AW_S:0] wc_s;

    fetch_sequencer #(.len(32), .ADDR_WIDTH(AW_B)) u_big (
        .clk(clk), .reset(reset), .in_rx_data(rx_data), .in_rx_valid(rx_valid), .in_halt(halt),
        .out_mem_we(we_b), .out_mem_addr(addr_b), .out_mem_wdata(wd_b), .out_pc_enable(pe_b),
        .out_pipe_reset(pr_b), .out_state(st_b), .out_word_count(wc_b), .out_error(err_b));

    fetch_sequencer #(.len(32), .ADDR_WIDTH(AW_S)) u_small (
        .clk(clk), .reset(reset), .in_rx_data(rx_data), .in_rx_valid(rx_valid), .in_halt(halt),
        .out_mem_we(we_s), .out_mem_addr(addr_s), .out_mem_wdata(wd_s), .out_pc_enable(pe_s),
        .out_pipe_reset(pr_s), .out_state(st_s), .out_word_count(wc_s), .out_error(err_s));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit prev_done = 0;

    typedef struct { int inst; int unsigned addr; logic [31:0] data; } wr_t;
    wr_t wr_log[$];
    int pe_cyc[2];
    int pe_rise[2];
    logic pe_prev[2];
    int excl_viol = 0;

    always @(negedge clk) begin
        if (we_b === 1'b1) wr_log.push_back('{0, 32'(addr_b), wd_b});
        if (we_s === 1'b1) wr_log.push_back('{1, 32'(addr_s), wd_s});
        if (pe_b === 1'b1) pe_cyc[0]++;
        if (pe_s === 1'b1) pe_cyc[1]++;
        if (pe_b === 1'b1 && pe_prev[0] !== 1'b1) pe_rise[0]++;
        if (pe_s === 1'b1 && pe_prev[1] !== 1'b1) pe_rise[1]++;
        pe_prev[0] = pe_b;
        pe_prev[1] = pe_s;
        if ((we_b & pe_b) === 1'b1 || (we_s & pe_s) === 1'b1) excl_viol++;
    end

    function automatic logic [2:0] ctrl3(input int k);
        return (k == 0) ? {we_b, pe_b, pr_b} : {we_s, pe_s, pr_s};
    endfunction
    function automatic logic [2:0] st(input int k);
        return (k == 0) ? st_b : st_s;
    endfunction
    function automatic logic [31:0] wc(input int k);
        return (k == 0) ? 32'(wc_b) : 32'(wc_s);
    endfunction
    function automatic logic errf(input int k);
        return (k == 0) ? err_b : err_s;
    endfunction
    function automatic logic [31:0] addrf(input int k);
        return (k == 0) ? 32'(addr_b) : 32'(addr_s);
    endfunction
    function automatic logic [31:0] wdf(input int k);
        return (k == 0) ? wd_b : wd_s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_data_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 254));
        while (b == B_L || b == B_C || b == B_S || b == B_N);
        return b;
    endfunction

    function automatic logic [31:0] rand_word();
        return {rand_data_byte(), rand_data_byte(), rand_data_byte(), rand_data_byte()};
    endfunction

    // Load model: bytes after 'L' form MSB-first words; each full word is
    // written at the next address until the halt word or a full RAM.
    logic [7:0]  stream[$];
    int unsigned m_addr[$];
    logic [31:0] m_data[$];
    int          m_wc;
    bit          m_err, m_idle;

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) stream.push_back(w[i*8 +: 8]);
    endtask

    task automatic model_load(input int cap);
        logic [31:0] w;
        m_addr.delete(); m_data.delete();
        m_wc = 0; m_err = 0; m_idle = 0;
        for (int i = 0; i + 3 < stream.size() && !m_idle; i += 4) begin
            w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
            m_addr.push_back(m_wc);
            m_data.push_back(w);
            m_wc++;
            if (w == HALT) m_idle = 1;
            else if (m_wc == cap) begin m_err = 1; m_idle = 1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; halt = 1'b0; rx_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ctrl3(k) !== 3'b001) begin n_errors++; $display("FAIL reset_ctrl[%0d] we/pe/pr: got %b want 001", k, ctrl3(k)); end
            n_checks++; if (st(k) !== 3'd0) begin n_errors++; $display("FAIL reset_state[%0d]: got %0d want 0", k, st(k)); end
            n_checks++; if (wc(k) !== 0 || errf(k) !== 1'b0) begin n_errors++; $display("FAIL reset_count_err[%0d]: got %0d/%b want 0/0", k, wc(k), errf(k)); end
            n_checks++; if (addrf(k) !== 0 || wdf(k) !== 0) begin n_errors++; $display("FAIL reset_addr_data[%0d]: got %0d/%h want 0/0", k, addrf(k), wdf(k)); end
        end
    endtask

    task automatic test_idle_noise();
        wr_log.delete();
        repeat (8) begin
            halt = 1'($urandom_range(0, 1));
            send_byte(rand_data_byte());
        end
        halt = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (st(k) !== 3'd0 || ctrl3(k) !== 3'b001) begin n_errors++; $display("FAIL idle_noise[%0d]: got state %0d ctrl %b want 0 001", k, st(k), ctrl3(k)); end
        end
        n_checks++; if (wr_log.size() != 0) begin n_errors++; $display("FAIL idle_noise_writes: got %0d want 0", wr_log.size()); end
    endtask

    task automatic test_load(input string name);
        int j;
        wr_log.delete();
        send_byte(B_L);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (st(k) !== 3'd1 || ctrl3(k) !== 3'b001) begin n_errors++; $display("FAIL %s_entry[%0d]: got state %0d ctrl %b want 1 001", name, k, st(k), ctrl3(k)); end
        end
        foreach (stream[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(stream[i]);
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            model_load(k == 0 ? (1 << AW_B) : (1 << AW_S));
            j = 0;
            foreach (wr_log[i]) begin
                if (wr_log[i].inst == k) begin
                    if (j < m_addr.size()) begin
                        n_checks++;
                        if (wr_log[i].addr !== m_addr[j] || wr_log[i].data !== m_data[j]) begin
                            n_errors++;
                            $display("FAIL %s_write[%0d][%0d]: got @%0d %h want @%0d %h", name, k, j, wr_log[i].addr, wr_log[i].data, m_addr[j], m_data[j]);
                        end
                    end
                    j++;
                end
            end
            n_checks++; if (j != m_addr.size()) begin n_errors++; $display("FAIL %s_nwrites[%0d]: got %0d want %0d", name, k, j, m_addr.size()); end
            n_checks++; if (wc(k) !== 32'(m_wc)) begin n_errors++; $display("FAIL %s_count[%0d]: got %0d want %0d", name, k, wc(k), m_wc); end
            n_checks++; if (errf(k) !== m_err) begin n_errors++; $display("FAIL %s_error[%0d]: got %b want %b", name, k, errf(k), m_err); end
            n_checks++; if (st(k) !== (m_idle ? 3'd0 : 3'd1)) begin n_errors++; $display("FAIL %s_state[%0d]: got %0d want %0d", name, k, st(k), m_idle ? 0 : 1); end
        end
        prev_done = 0;
    endtask

    task automatic test_run(input int d);
        pe_cyc[0] = 0; pe_cyc[1] = 0;
        send_byte(B_C);
        if (prev_done) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (ctrl3(k) !== 3'b001 || st(k) !== 3'd4) begin n_errors++; $display("FAIL run_restart[%0d]: got ctrl %b state %0d want 001 4", k, ctrl3(k), st(k)); end
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ctrl3(k) !== 3'b010 || st(k) !== 3'd2) begin n_errors++; $display("FAIL run_start[%0d]: got ctrl %b state %0d want 010 2", k, ctrl3(k), st(k)); end
        end
        for (int i = 1; i < d; i++) begin
            if (i == 1) begin rx_data = B_L; rx_valid = 1'b1; end
            tick();
            rx_valid = 1'b0;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ctrl3(k) !== 3'b000 || st(k) !== 3'd4) begin n_errors++; $display("FAIL run_halt[%0d]: got ctrl %b state %0d want 000 4", k, ctrl3(k), st(k)); end
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (pe_cyc[k] != d) begin n_errors++; $display("FAIL run_pc_cycles[%0d]: got %0d want %0d", k, pe_cyc[k], d); end
        end
        prev_done = 1;
    endtask

    task automatic test_step(input int n, input int spacing);
        send_byte(B_S);
        if (prev_done) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (ctrl3(k) !== 3'b001 || st(k) !== 3'd4) begin n_errors++; $display("FAIL step_restart[%0d]: got ctrl %b state %0d want 001 4", k, ctrl3(k), st(k)); end
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ctrl3(k) !== 3'b000 || st(k) !== 3'd3) begin n_errors++; $display("FAIL step_enter[%0d]: got ctrl %b state %0d want 000 3", k, ctrl3(k), st(k)); end
        end
        pe_cyc[0] = 0; pe_cyc[1] = 0; pe_rise[0] = 0; pe_rise[1] = 0;
        for (int p = 0; p < n; p++) begin
            repeat (spacing - 1) begin
                rx_data  = rand_data_byte();
                rx_valid = 1'($urandom_range(0, 1));
                tick();
                rx_valid = 1'b0;
            end
            send_byte(B_N);
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (ctrl3(k) !== 3'b010 || st(k) !== 3'd3) begin n_errors++; $display("FAIL step_pulse[%0d][%0d]: got ctrl %b state %0d want 010 3", k, p, ctrl3(k), st(k)); end
            end
            tick();
        end
        rx_data = B_N; rx_valid = 1'b1; halt = 1'b1;
        tick();
        rx_valid = 1'b0; halt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ctrl3(k) !== 3'b000 || st(k) !== 3'd4) begin n_errors++; $display("FAIL step_halt[%0d]: got ctrl %b state %0d want 000 4", k, ctrl3(k), st(k)); end
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (pe_cyc[k] != n || pe_rise[k] != n) begin n_errors++; $display("FAIL step_pulses[%0d]: got %0d cycles %0d pulses want %0d", k, pe_cyc[k], pe_rise[k], n); end
        end
        prev_done = 1;
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        stream.delete();
        send_byte(B_L);
        repeat (6) begin
            stream.push_back(rand_data_byte());
            send_byte(stream[stream.size()-1]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ctrl3(k) !== 3'b001 || st(k) !== 3'd0) begin n_errors++; $display("FAIL midreset_ctrl[%0d]: got ctrl %b state %0d want 001 0", k, ctrl3(k), st(k)); end
            n_checks++; if (wc(k) !== 0 || addrf(k) !== 0 || wdf(k) !== 0) begin n_errors++; $display("FAIL midreset_regs[%0d]: got wc %0d addr %0d data %h want 0", k, wc(k), addrf(k), wdf(k)); end
        end
        n_checks++; if (wr_log.size() != 2) begin n_errors++; $display("FAIL midreset_prewrites: got %0d want 2", wr_log.size()); end
        stream.delete();
        push_word(HALT);
        test_load("reload");
    endtask

    task automatic test_exclusive();
        n_checks++; if (excl_viol != 0) begin n_errors++; $display("FAIL we_pc_exclusive: got %0d overlaps want 0", excl_viol); end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; halt = 1'b0;
        test_reset();
        test_idle_noise();
        stream.delete(); push_word(32'h2001_0005); push_word(32'h0); push_word(HALT);
        test_load("load_basic");
        test_run(7);
        test_step(3, 5);
        test_run($urandom_range(2, 12));
        stream.delete(); repeat (20) stream.push_back(rand_data_byte()); push_word(HALT);
        test_load("load_overflow");
        stream.delete(); repeat ($urandom_range(0, 5)) push_word(rand_word()); push_word(HALT);
        test_load("load_random");
        test_step($urandom_range(1, 4), $urandom_range(2, 6));
        test_run($urandom_range(2, 12));
        test_reset_mid();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
